alu_sequencer: RTL and testbench

Sequential issue/response controller that sits in front of the 32-bit combinational ALU (AND/OR/ADD with B-invert and carry-in). It accepts operation requests over a valid/ready handshake and drives the ALU's control and operand inputs. It captures the ALU result and carry-out and returns them with status flags over a second valid/ready handshake. It adds SUB and SLT, which map onto the ALU add path, and optionally a multi-cycle shift-add MUL that reuses the ALU adder.

---
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/alu_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between a requester and alu_sequencer.
interface alu_sequencer_if;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 3;

  logic          req_valid;
  logic          req_ready;
  logic [OW-1:0] req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_cout;
  logic          rsp_zero;
  logic          rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issue/response sequencer in front of a 32-bit combinational AND/OR/ADD ALU.
// Adds SUB and SLT on the add path. Define ALU_SEQ_MUL_EN to enable the
// 32-cycle shift-add MUL (opcode 101); otherwise opcode 101 is illegal.
// Every output is a flop; ALU drive is registered from next-state values so
// it is already valid during the EXEC/MUL cycle it belongs to.
module alu_sequencer (
  input  logic                clk,
  input  logic                rst_n,
  alu_sequencer_if.slave      bus,
  output logic [31:0]         alu_in1,
  output logic [31:0]         alu_in2,
  output logic [1:0]          alu_sel,
  output logic                alu_cin,
  output logic                alu_binv,
  input  logic [31:0]         alu_out,
  input  logic                alu_cout
);
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 3;
  localparam int unsigned SW = 2;

  localparam logic [OW-1:0] OP_AND = 3'b000;
  localparam logic [OW-1:0] OP_OR  = 3'b001;
  localparam logic [OW-1:0] OP_ADD = 3'b010;
  localparam logic [OW-1:0] OP_SUB = 3'b011;
  localparam logic [OW-1:0] OP_SLT = 3'b100;

  localparam logic [SW-1:0] SEL_AND = 2'b00;
  localparam logic [SW-1:0] SEL_OR  = 2'b01;
  localparam logic [SW-1:0] SEL_ADD = 2'b10;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned   CW     = 5;
  localparam logic [OW-1:0] OP_MUL = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_e;
  logic [DW-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
`endif

  state_e        state_q, state_d;
  logic [OW-1:0] op_q, op_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] result_q, result_d;
  logic          cout_q, cout_d, zero_q, zero_d, err_q, err_d;
  logic          req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
  logic [SW-1:0] alu_sel_q, alu_sel_d;
  logic          alu_cin_q, alu_cin_d, alu_binv_q, alu_binv_d;
  logic          ovf_c;

  // Signed-overflow term of a_q - b_q for the SLT compare.
  assign ovf_c = (a_q[DW-1] != b_q[DW-1]) && (alu_out[DW-1] != a_q[DW-1]);

  // Next-state, operand capture, result capture and registered output drive.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    cout_d     = cout_q;
    zero_d     = zero_q;
    err_d      = err_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          state_d = S_EXEC;
`ifdef ALU_SEQ_MUL_EN
          if (bus.req_op == OP_MUL) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = bus.req_a;
            mplier_d = bus.req_b;
            cnt_d    = '0;
          end
`endif
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        cout_d  = 1'b0;
        err_d   = 1'b0;
        case (op_q)
          OP_AND, OP_OR: result_d = alu_out;
          OP_ADD, OP_SUB: begin
            result_d = alu_out;
            cout_d   = alu_cout;
          end
          OP_SLT:  result_d = DW'(alu_out[DW-1] ^ ovf_c);
          default: begin
            result_d = '0;
            err_d    = 1'b1;
          end
        endcase
        zero_d = (result_d == '0);
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        if (mplier_q[0]) acc_d = alu_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d  = S_RESP;
          result_d = acc_d;
          cout_d   = 1'b0;
          err_d    = 1'b0;
          zero_d   = (acc_d == '0);
        end
      end
`endif
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);

    alu_in1_d  = a_d;
    alu_in2_d  = b_d;
    alu_sel_d  = SEL_AND;
    alu_cin_d  = 1'b0;
    alu_binv_d = 1'b0;
    if (state_d == S_EXEC) begin
      case (op_d)
        OP_OR:  alu_sel_d = SEL_OR;
        OP_ADD: alu_sel_d = SEL_ADD;
        OP_SUB, OP_SLT: begin
          alu_sel_d  = SEL_ADD;
          alu_binv_d = 1'b1;
          alu_cin_d  = 1'b1;
        end
        default: alu_sel_d = SEL_AND;
      endcase
    end
`ifdef ALU_SEQ_MUL_EN
    if (state_d == S_MUL) begin
      alu_in1_d = acc_d;
      alu_in2_d = mcand_d;
      alu_sel_d = SEL_ADD;
    end
`endif
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_sel_q   <= '0;
      alu_cin_q   <= 1'b0;
      alu_binv_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_sel_q   <= alu_sel_d;
      alu_cin_q   <= alu_cin_d;
      alu_binv_q  <= alu_binv_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;
  assign alu_in1        = alu_in1_q;
  assign alu_in2        = alu_in2_q;
  assign alu_sel        = alu_sel_q;
  assign alu_cin        = alu_cin_q;
  assign alu_binv       = alu_binv_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed test-plan cases followed by
// randomized transactions, all checked against an arithmetic reference model.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [1:0]  alu_sel;
  logic        alu_cin, alu_binv, alu_cout;
  logic [31:0] bx;
  logic [32:0] sum;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_sel  (alu_sel),
    .alu_cin  (alu_cin),
    .alu_binv (alu_binv),
    .alu_out  (alu_out),
    .alu_cout (alu_cout)
  );

  // Combinational ALU the sequencer drives.
  always_comb begin
    bx       = alu_binv ? ~alu_in2 : alu_in2;
    sum      = {1'b0, alu_in1} + {1'b0, bx} + {32'b0, alu_cin};
    alu_cout = 1'b0;
    case (alu_sel)
      2'b00:   alu_out = alu_in1 & bx;
      2'b01:   alu_out = alu_in1 | bx;
      2'b10: begin
        alu_out  = sum[31:0];
        alu_cout = sum[32];
      end
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit mul_enabled();
`ifdef ALU_SEQ_MUL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour of one operation, from the arithmetic definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c, output logic z, output logic e);
    logic [32:0] s;
    c = 1'b0;
    e = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
      end
      3'd3: begin
        r = a - b;
        c = (a >= b);
      end
      3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: begin
        if (mul_enabled()) r = a * b;
        else begin
          r = '0;
          e = 1'b1;
        end
      end
      default: begin
        r = '0;
        e = 1'b1;
      end
    endcase
    z = (r == '0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"},  bus.req_ready,  32'd1);
    chk({tag, "_rsp_valid"},  bus.rsp_valid,  32'd0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
    chk({tag, "_rsp_cout"},   bus.rsp_cout,   32'd0);
    chk({tag, "_rsp_zero"},   bus.rsp_zero,   32'd0);
    chk({tag, "_rsp_err"},    bus.rsp_err,    32'd0);
    chk({tag, "_alu_in1"},    alu_in1,        32'd0);
    chk({tag, "_alu_in2"},    alu_in2,        32'd0);
    chk({tag, "_alu_sel"},    alu_sel,        32'd0);
    chk({tag, "_alu_cin"},    alu_cin,        32'd0);
    chk({tag, "_alu_binv"},   alu_binv,       32'd0);
  endtask

  // Check the ALU drive during the first execute cycle of an operation.
  task automatic check_drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [1:0]  es;
    logic        eb;
    logic [31:0] e1, e2;
    es = 2'b00; eb = 1'b0; e1 = a; e2 = b;
    case (op)
      3'd1: es = 2'b01;
      3'd2: es = 2'b10;
      3'd3, 3'd4: begin es = 2'b10; eb = 1'b1; end
      3'd5: if (mul_enabled()) begin es = 2'b10; e1 = 32'd0; e2 = a; end
      default: es = 2'b00;
    endcase
    chk("drv_sel",  alu_sel,  32'(es));
    chk("drv_binv", alu_binv, 32'(eb));
    chk("drv_cin",  alu_cin,  32'(eb));
    chk("drv_in1",  alu_in1,  e1);
    chk("drv_in2",  alu_in2,  e2);
  endtask

  // One full transaction; hold = cycles of rsp_ready backpressure,
  // pulse = drive a stray req_valid while the response is held.
  task automatic txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int hold, input bit pulse);
    logic [31:0] er;
    logic        ec, ez, ee;
    int          n, lat;
    model(op, a, b, er, ec, ez, ee);
    lat = (op == 3'd5 && mul_enabled()) ? 32 : 1;
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = (hold == 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    chk("req_ready_busy", bus.req_ready, 32'd0);
    check_drive(op, a, b);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("result", bus.rsp_result, er);
    chk("cout",   bus.rsp_cout,   32'(ec));
    chk("zero",   bus.rsp_zero,   32'(ez));
    chk("err",    bus.rsp_err,    32'(ee));
    chk("req_ready_resp", bus.req_ready, 32'd0);
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 1) begin
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd2;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("hold_valid",  bus.rsp_valid,  32'd1);
      chk("hold_result", bus.rsp_result, er);
      chk("hold_err",    bus.rsp_err,    32'(ee));
      chk("hold_ready",  bus.req_ready,  32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("done_valid", bus.rsp_valid, 32'd0);
    chk("done_ready", bus.req_ready, 32'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_rst");

    txn(3'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0);
    txn(3'd1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 0);
    txn(3'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0);
    txn(3'd2, 32'hFFFFFFFF, 32'h00000001, 0, 0);
    txn(3'd3, 32'd5, 32'd7, 0, 0);
    txn(3'd3, 32'd7, 32'd5, 2, 0);
    txn(3'd4, 32'hFFFFFFFF, 32'h00000001, 0, 0);
    txn(3'd4, 32'h80000000, 32'h7FFFFFFF, 0, 0);
    txn(3'd4, 32'h7FFFFFFF, 32'h80000000, 0, 0);
    txn(3'd5, 32'h00001234, 32'h00000010, 0, 0);
    txn(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    txn(3'd6, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    txn(3'd7, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    txn(3'd2, 32'h00000010, 32'h00000020, 5, 1);

    // Reset in the middle of an operation: no response may follow.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = mul_enabled() ? 3'd5 : 3'd2;
    bus.req_a     = 32'h0000ABCD;
    bus.req_b     = 32'h00FF00FF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (mul_enabled()) repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      chk("no_rsp_after_rst", bus.rsp_valid, 32'd0);
    end
    txn(3'd2, 32'd1, 32'd2, 0, 0);

    for (int t = 0; t < 40; t++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($urandom_range(0, 15)); b = 32'($urandom_range(0, 15)); end
        2: begin a = 32'h80000000; b = $urandom; end
        default: begin a = 32'hFFFFFFFF; b = $urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h1; end
      endcase
      txn(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
